// File: rtl/ddr_bitstream_fetch.sv
// Fetches a linear run of 32-bit words from a DDR controller local port and streams them out.
// Optional build macro BS_FETCH_BYTE_SWAP_EN byte-reverses each output word.
module ddr_bitstream_fetch #(
  parameter int unsigned BURST_LEN  = 2,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = 23
) (
  input  logic              phy_clk,
  input  logic              reset_phy_clk_n,
  input  logic              local_init_done,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  input  logic              local_ready,
  output logic              local_read_req,
  output logic              local_burstbegin,
  output logic [ADDR_W-1:0] local_address,
  output logic [2:0]        local_size,
  input  logic [31:0]       local_rdata,
  input  logic              local_rdata_valid,
  output logic [31:0]       bs_data,
  output logic              bs_valid,
  input  logic              bs_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = CW + 2;

  typedef enum logic [1:0] {StIdle, StWaitInit, StIssue, StDrain} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q, rem_q;
  logic [CW-1:0]     pend_q, cnt_q;
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [31:0]       mem_q [FIFO_DEPTH];

  logic              accept, beat_ok, pop, push, credit_ok, issue;
  logic [ADDR_W-1:0] rem_n, addr_n;
  logic [CW-1:0]     pend_n, cnt_n;
  logic [2:0]        size_n;
  logic [31:0]       fifo_word;

  always_comb begin
    accept  = local_read_req & local_ready;
    // Beats with nothing outstanding are leftovers from an abandoned fetch.
    beat_ok = local_rdata_valid & (pend_q != '0);
    pop     = bs_valid & bs_ready;
    push    = beat_ok & ((cnt_q != CW'(FIFO_DEPTH)) | pop);
    rem_n   = accept ? rem_q - ADDR_W'(local_size) : rem_q;
    addr_n  = accept ? addr_q + ADDR_W'(local_size) : addr_q;
    pend_n  = pend_q + (accept ? CW'(local_size) : '0) - CW'(beat_ok);
    cnt_n   = cnt_q + CW'(push) - CW'(pop);
    size_n  = (rem_n < ADDR_W'(BURST_LEN)) ? rem_n[2:0] : 3'(BURST_LEN);
    // Credit is judged on post-edge occupancy so a new burst can follow an acceptance directly.
    credit_ok = (SW'(cnt_n) + SW'(pend_n) + SW'(size_n)) <= SW'(FIFO_DEPTH);
    issue     = (state_q == StIssue) & (~local_read_req | accept) & (rem_n != '0) & credit_ok;
  end

  always_ff @(posedge phy_clk) begin
    if (!reset_phy_clk_n) begin
      state_q          <= StIdle;
      addr_q           <= '0;
      rem_q            <= '0;
      pend_q           <= '0;
      cnt_q            <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      local_read_req   <= 1'b0;
      local_burstbegin <= 1'b0;
      local_address    <= '0;
      local_size       <= '0;
      done             <= 1'b0;
    end else begin
      done     <= 1'b0;
      cnt_q    <= cnt_n;
      pend_q   <= pend_n;
      addr_q   <= addr_n;
      rem_q    <= rem_n;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;

      if (issue) begin
        local_read_req   <= 1'b1;
        local_burstbegin <= 1'b1;
        local_address    <= addr_n;
        local_size       <= size_n;
      end else if (accept) begin
        local_read_req   <= 1'b0;
        local_burstbegin <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            if (word_count == '0) begin
              done <= 1'b1;
            end else begin
              addr_q  <= base_addr;
              rem_q   <= word_count;
              state_q <= StWaitInit;
            end
          end
        end
        StWaitInit: if (local_init_done) state_q <= StIssue;
        StIssue:    if (accept && (rem_n == '0)) state_q <= StDrain;
        StDrain: begin
          if ((pend_n == '0) && (cnt_n == '0)) begin
            state_q <= StIdle;
            done    <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Storage needs no reset; occupancy gates everything visible.
  always_ff @(posedge phy_clk) begin
    if (push) mem_q[wr_ptr_q] <= local_rdata;
  end

  assign fifo_word = mem_q[rd_ptr_q];
  assign bs_valid  = (cnt_q != '0);
  assign busy      = (state_q != StIdle);

`ifdef BS_FETCH_BYTE_SWAP_EN
  assign bs_data = bs_valid ? {fifo_word[7:0], fifo_word[15:8], fifo_word[23:16], fifo_word[31:24]}
                            : 32'h0;
`else
  assign bs_data = bs_valid ? fifo_word : 32'h0;
`endif

endmodule

// File: doc/ddr_bitstream_fetch.md
DDR_BITSTREAM_FETCH -- requirements
Module: ddr_bitstream_fetch

Interface
REQ-001 SHALL provide parameter BURST_LEN, default 2, words per read burst (legal 1..4), driven on local_size.
REQ-002 SHALL provide parameter FIFO_DEPTH, default 16, 32-bit output FIFO entries (power of two, >= 2*BURST_LEN).
REQ-003 SHALL provide parameter ADDR_W, default 23, controller word-address width.
REQ-004 SHALL use one clock and a synchronous, active-low reset; ports phy_clk and reset_phy_clk_n.
REQ-005 phy_clk  in  1  controller clock; all logic rising-edge.
REQ-006 reset_phy_clk_n  in  1  synchronous active-low reset.
REQ-007 local_init_done  in  1  controller calibration complete.
REQ-008 start  in  1  one-cycle pulse that launches a fetch; sampled only in IDLE.
REQ-009 base_addr  in  ADDR_W  first word address, captured on start.
REQ-010 word_count  in  ADDR_W  words to fetch, captured on start; 0 means complete immediately.
REQ-011 local_ready  in  1  controller accepts the request this cycle.
REQ-012 local_read_req / local_burstbegin  out  1  read request and burst start.
REQ-013 local_address  out  ADDR_W; local_size  out  3  request address and burst length.
REQ-014 local_rdata  in  32; local_rdata_valid  in  1  returned read beats.
REQ-015 bs_data  out  32; bs_valid  out  1; bs_ready  in  1  bitstream stream to decoder (valid/ready).
REQ-016 busy  out  1  fetch active; done  out  1  one-cycle pulse when the last word leaves the FIFO.

Function
REQ-017 States SHALL be IDLE, WAIT_INIT, ISSUE, DRAIN. IDLE->WAIT_INIT on start (word_count != 0); WAIT_INIT->ISSUE once local_init_done=1; ISSUE->DRAIN when the last request is accepted; DRAIN->IDLE when pending=0 and the FIFO is empty.
REQ-018 start with word_count=0 SHALL pulse done on the next cycle and stay in IDLE.
REQ-019 Request size SHALL be min(BURST_LEN, remaining); the address advances by that size after each accepted request.
REQ-020 A request SHALL issue only when (FIFO occupancy + pending beats + size) <= FIFO_DEPTH; pending beats increment by size on acceptance and decrement on each local_rdata_valid.
REQ-021 local_read_req, local_burstbegin, local_address and local_size SHALL assert together and hold stable until the cycle in which local_ready=1; acceptance happens in that cycle.
REQ-022 Back-to-back requests SHALL be allowed: the next request may assert the cycle after acceptance.
REQ-023 Each local_rdata_valid beat SHALL write the FIFO on that edge with zero wait; bs_valid SHALL rise no later than one cycle after the write.
REQ-024 Simultaneous FIFO write and read SHALL keep occupancy unchanged; the credit rule in REQ-020 makes overflow unreachable, and a write at full SHALL be dropped.
REQ-025 Beats arriving while pending=0 (stale after reset) SHALL be discarded.
REQ-026 Address arithmetic SHALL wrap modulo 2^ADDR_W without error.
REQ-027 busy SHALL be 1 in every state except IDLE; start outside IDLE SHALL be ignored.

Reset
REQ-028 With reset_phy_clk_n=0 at an edge: state IDLE; FIFO, pending and counters cleared; all outputs 0 (local_size 0, local_address 0).
REQ-029 Reset mid-burst SHALL abandon the fetch; no further request is issued, and in-flight beats are dropped per REQ-025.

Configuration
REQ-030 Macro BS_FETCH_BYTE_SWAP_EN defined: bs_data SHALL be the FIFO word byte-reversed ({[7:0],[15:8],[23:16],[31:24]}); undefined: bs_data SHALL equal the FIFO word unchanged. Timing is identical in both builds.

Verification
REQ-031 base=0x100, count=8, ready=1, read latency 6 -> 4 requests at 0x100/0x102/0x104/0x106 with size 2; 8 words in order; done pulses once.
REQ-032 count=5, BURST_LEN=2 -> sizes 2,2,1 at addresses base, base+2, base+4.
REQ-033 bs_ready=0 throughout, count=64 -> requests stop with occupancy+pending=16; no overflow; resume when bs_ready=1.
REQ-034 local_init_done=0 for 100 cycles after start -> no read_req until it rises; local_ready low 3 cycles -> request fields held stable.
REQ-035 Reset asserted 2 cycles after the first acceptance, followed by 2 late valid beats -> outputs 0, FIFO empty, beats dropped, busy=0.
REQ-036 BS_FETCH_BYTE_SWAP_EN defined, rdata 0x00000001 -> bs_data 0x01000000; start with count=0 -> done pulses one cycle later and no request is issued.
